scr1_mem_arb: RTL and testbench



---
 rtl/scr1_mem_arb_pkg.sv | 26 ++
 rtl/scr1_mem_arb_if.sv | 16 +
 rtl/scr1_arb_id_fifo.sv | 62 ++++++
 rtl/scr1_mem_arb.sv | 83 ++++++++
 tb/tb_scr1_mem_arb.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/scr1_mem_arb_pkg.sv
// Shared memory-interface types for the imem/dmem arbiter and its owner-ID FIFO.
package scr1_mem_arb_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic {
    SCR1_ARB_IMEM = 1'b0,
    SCR1_ARB_DMEM = 1'b1
  } type_scr1_arb_id_e;

endpackage

// File: rtl/scr1_mem_arb_if.sv
// One pipelined memory port: request/accept handshake plus in-order response.
interface scr1_mem_arb_if;
  import scr1_mem_arb_pkg::*;

  logic                 req;
  logic                 req_ack;
  type_scr1_mem_cmd_e   cmd;
  type_scr1_mem_width_e width;
  logic [31:0]          addr;
  logic [31:0]          wdata;
  logic [31:0]          rdata;
  type_scr1_mem_resp_e  resp;

  modport master (output req, cmd, width, addr, wdata, input req_ack, rdata, resp);
  modport slave  (input req, cmd, width, addr, wdata, output req_ack, rdata, resp);
endinterface

// File: rtl/scr1_arb_id_fifo.sv
// Small circular FIFO, one-cycle write-to-read; push is dropped when full unless
// a pop happens in the same cycle, pop is ignored when empty.
module scr1_arb_id_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [WIDTH-1:0]             data_i,
  input  logic                         pop_i,
  output logic [WIDTH-1:0]             head_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[head_q];
  assign count_o = count_q;

  always_comb begin
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    head_d  = do_pop  ? ptr_inc(head_q) : head_q;
    tail_d  = do_push ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[tail_q] <= data_i;
  end
endmodule

// File: rtl/scr1_mem_arb.sv
// Shares one pipelined memory port between imem and dmem; request path is zero-latency,
// grants are withheld while the owner-ID FIFO is full and no response frees a slot.
module scr1_mem_arb
  import scr1_mem_arb_pkg::*;
#(
  parameter int SCR1_ARB_OUTST     = 2,
  parameter bit SCR1_ARB_DMEM_PRIO = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  scr1_mem_arb_if.slave  imem_if,
  scr1_mem_arb_if.slave  dmem_if,
  scr1_mem_arb_if.master mem_if
);
  localparam int CNT_W = $clog2(SCR1_ARB_OUTST + 1);

  logic              fifo_full, fifo_empty;
  logic [0:0]        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  type_scr1_arb_id_e owner, rr_last_q, rr_last_d;
  logic              resp_pop, fifo_ok;
  logic              imem_cand, dmem_cand, imem_gnt, dmem_gnt, accept;

  assign owner    = type_scr1_arb_id_e'(fifo_head);
  assign resp_pop = ~rst & (mem_if.resp != SCR1_MEM_RESP_NOTRDY) & ~fifo_empty;
  assign fifo_ok  = ~rst & (~fifo_full | resp_pop);

  // Round-robin favours whoever was not granted last; fixed mode always favours dmem.
  assign imem_cand = imem_if.req & fifo_ok;
  assign dmem_cand = dmem_if.req & fifo_ok;
  assign dmem_gnt  = dmem_cand & (~imem_cand | SCR1_ARB_DMEM_PRIO | (rr_last_q == SCR1_ARB_IMEM));
  assign imem_gnt  = imem_cand & ~dmem_gnt;
  assign accept    = mem_if.req_ack & mem_if.req;

  assign mem_if.req   = imem_gnt | dmem_gnt;
  assign mem_if.cmd   = dmem_gnt ? dmem_if.cmd   : SCR1_MEM_CMD_RD;
  assign mem_if.width = dmem_gnt ? dmem_if.width : SCR1_MEM_WIDTH_WORD;
  assign mem_if.addr  = dmem_gnt ? dmem_if.addr  : imem_if.addr;
  assign mem_if.wdata = dmem_if.wdata;

  assign imem_if.req_ack = accept & imem_gnt;
  assign dmem_if.req_ack = accept & dmem_gnt;

  assign imem_if.resp  = (resp_pop && owner == SCR1_ARB_IMEM) ? mem_if.resp : SCR1_MEM_RESP_NOTRDY;
  assign dmem_if.resp  = (resp_pop && owner == SCR1_ARB_DMEM) ? mem_if.resp : SCR1_MEM_RESP_NOTRDY;
  assign imem_if.rdata = mem_if.rdata;
  assign dmem_if.rdata = mem_if.rdata;

  always_comb begin
    rr_last_d = rr_last_q;
    if (accept) rr_last_d = dmem_gnt ? SCR1_ARB_DMEM : SCR1_ARB_IMEM;
  end

  always_ff @(posedge clk) begin
    if (rst) rr_last_q <= SCR1_ARB_DMEM;
    else     rr_last_q <= rr_last_d;
  end

  scr1_arb_id_fifo #(
    .DEPTH (SCR1_ARB_OUTST),
    .WIDTH (1)
  ) u_id_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .data_i  (dmem_gnt),
    .pop_i   (resp_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifndef SYNTHESIS
  a_no_x: assert property (@(posedge clk) !$isunknown({imem_if.req, dmem_if.req, mem_if.resp}));
  a_one_ack: assert property (@(posedge clk) !(imem_if.req_ack && dmem_if.req_ack));
  a_cnt_max: assert property (@(posedge clk) fifo_count <= CNT_W'(SCR1_ARB_OUTST));
  a_imem_align: assert property (@(posedge clk) disable iff (rst)
    imem_if.req |-> (imem_if.addr[1:0] == 2'b00));
  a_resp_orphan: assert property (@(posedge clk) disable iff (rst)
    (mem_if.resp != SCR1_MEM_RESP_NOTRDY) |-> (fifo_count != '0));
`endif
endmodule

// File: tb/tb_scr1_mem_arb.sv
// Directed bench: queue-based ownership model checks the round-robin DUT every cycle;
// a fixed-priority DUT shares the stimulus and is pinned by literal expectations.
module tb_scr1_mem_arb;
  import scr1_mem_arb_pkg::*;

  localparam int OUTST = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 ireq, dreq, mack;
  logic [31:0]          ia, da, dwd, mrd;
  type_scr1_mem_cmd_e   dcmd;
  type_scr1_mem_width_e dw;
  type_scr1_mem_resp_e  mresp;

  scr1_mem_arb_if i1(), d1(), m1();
  scr1_mem_arb_if i2(), d2(), m2();

  assign i1.req = ireq; assign i1.addr = ia; assign i1.cmd = SCR1_MEM_CMD_RD;
  assign i1.width = SCR1_MEM_WIDTH_WORD; assign i1.wdata = '0;
  assign d1.req = dreq; assign d1.addr = da; assign d1.cmd = dcmd;
  assign d1.width = dw; assign d1.wdata = dwd;
  assign m1.req_ack = mack; assign m1.resp = mresp; assign m1.rdata = mrd;

  assign i2.req = ireq; assign i2.addr = ia; assign i2.cmd = SCR1_MEM_CMD_RD;
  assign i2.width = SCR1_MEM_WIDTH_WORD; assign i2.wdata = '0;
  assign d2.req = dreq; assign d2.addr = da; assign d2.cmd = dcmd;
  assign d2.width = dw; assign d2.wdata = dwd;
  assign m2.req_ack = mack; assign m2.resp = mresp; assign m2.rdata = mrd;

  scr1_mem_arb #(.SCR1_ARB_OUTST(OUTST), .SCR1_ARB_DMEM_PRIO(1'b0)) u_rr (
    .clk(clk), .rst(rst), .imem_if(i1), .dmem_if(d1), .mem_if(m1));
  scr1_mem_arb #(.SCR1_ARB_OUTST(OUTST), .SCR1_ARB_DMEM_PRIO(1'b1)) u_prio (
    .clk(clk), .rst(rst), .imem_if(i2), .dmem_if(d2), .mem_if(m2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Ownership model: a queue of who issued each outstanding request, oldest first.
  type_scr1_arb_id_e oq[$];
  type_scr1_arb_id_e m_last = SCR1_ARB_DMEM;

  always @(negedge clk) begin : model
    bit pop, room, gi, gd;
    type_scr1_mem_resp_e ei, ed;
    if (rst) begin
      chk("m_rst_mem_req", 32'(m1.req), 32'(0));
      chk("m_rst_i_ack", 32'(i1.req_ack), 32'(0));
      chk("m_rst_d_ack", 32'(d1.req_ack), 32'(0));
      chk("m_rst_i_resp", 32'(i1.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      chk("m_rst_d_resp", 32'(d1.resp), 32'(SCR1_MEM_RESP_NOTRDY));
      oq.delete();
      m_last = SCR1_ARB_DMEM;
    end else begin
      pop  = (mresp != SCR1_MEM_RESP_NOTRDY) && (oq.size() != 0);
      room = (oq.size() < OUTST) || pop;
      gi   = room && ireq && !(dreq && m_last == SCR1_ARB_IMEM);
      gd   = room && dreq && !gi;
      chk("m_mem_req", 32'(m1.req), 32'(gi | gd));
      chk("m_i_ack", 32'(i1.req_ack), 32'(gi & mack));
      chk("m_d_ack", 32'(d1.req_ack), 32'(gd & mack));
      if (gi) begin
        chk("m_addr_i", m1.addr, ia);
        chk("m_cmd_i", 32'(m1.cmd), 32'(SCR1_MEM_CMD_RD));
        chk("m_width_i", 32'(m1.width), 32'(SCR1_MEM_WIDTH_WORD));
      end
      if (gd) begin
        chk("m_addr_d", m1.addr, da);
        chk("m_cmd_d", 32'(m1.cmd), 32'(dcmd));
        chk("m_width_d", 32'(m1.width), 32'(dw));
        if (dcmd == SCR1_MEM_CMD_WR) chk("m_wdata_d", m1.wdata, dwd);
      end
      ei = (pop && oq[0] == SCR1_ARB_IMEM) ? mresp : SCR1_MEM_RESP_NOTRDY;
      ed = (pop && oq[0] == SCR1_ARB_DMEM) ? mresp : SCR1_MEM_RESP_NOTRDY;
      chk("m_i_resp", 32'(i1.resp), 32'(ei));
      chk("m_d_resp", 32'(d1.resp), 32'(ed));
      if (pop) begin
        if (oq[0] == SCR1_ARB_IMEM) chk("m_i_rdata", i1.rdata, mrd);
        else                        chk("m_d_rdata", d1.rdata, mrd);
        void'(oq.pop_front());
      end
      if (mack && (gi || gd)) begin
        oq.push_back(gd ? SCR1_ARB_DMEM : SCR1_ARB_IMEM);
        m_last = gd ? SCR1_ARB_DMEM : SCR1_ARB_IMEM;
      end
    end
  end

  task automatic smp(); @(negedge clk); endtask
  task automatic nxt(); @(posedge clk); #1; endtask
  task automatic iq(input logic r, input logic [31:0] a); ireq = r; ia = a; endtask
  task automatic dq(input logic r, input type_scr1_mem_cmd_e c, input type_scr1_mem_width_e w,
                    input logic [31:0] a, input logic [31:0] wd);
    dreq = r; dcmd = c; dw = w; da = a; dwd = wd;
  endtask
  task automatic ds(input logic ack, input type_scr1_mem_resp_e r, input logic [31:0] d);
    mack = ack; mresp = r; mrd = d;
  endtask

  localparam type_scr1_mem_resp_e NR = SCR1_MEM_RESP_NOTRDY;
  localparam type_scr1_mem_resp_e OK = SCR1_MEM_RESP_RDY_OK;
  localparam type_scr1_mem_resp_e ER = SCR1_MEM_RESP_RDY_ER;
  localparam type_scr1_mem_cmd_e  RD = SCR1_MEM_CMD_RD;
  localparam type_scr1_mem_cmd_e  WR = SCR1_MEM_CMD_WR;
  localparam type_scr1_mem_width_e WW = SCR1_MEM_WIDTH_WORD;

  initial begin
    rst = 1'b1;
    iq(0, 0); dq(0, RD, WW, 0, 0); ds(0, NR, 0);
    smp(); nxt();
    smp();
    chk("rst_mem_req", 32'(m1.req), 32'(0));
    chk("rst_i_resp", 32'(i1.resp), 32'(NR));
    nxt();
    rst = 1'b0;

    // Contention: RR alternates from imem, fixed priority always picks dmem.
    iq(1, 32'h200); dq(1, RD, WW, 32'h1000, 0); ds(1, NR, 0);
    smp(); chk("rr_c0_i_ack", 32'(i1.req_ack), 32'(1)); chk("rr_c0_addr", m1.addr, 32'h200);
    chk("pr_c0_d_ack", 32'(d2.req_ack), 32'(1)); chk("pr_c0_i_ack", 32'(i2.req_ack), 32'(0));
    nxt();
    iq(1, 32'h204); ds(1, OK, 32'hA01);
    smp(); chk("rr_c1_d_ack", 32'(d1.req_ack), 32'(1)); chk("rr_c1_i_resp", 32'(i1.resp), 32'(OK));
    chk("rr_c1_i_rdata", i1.rdata, 32'hA01);
    chk("pr_c1_d_ack", 32'(d2.req_ack), 32'(1)); chk("pr_c1_i_ack", 32'(i2.req_ack), 32'(0));
    chk("pr_c1_d_resp", 32'(d2.resp), 32'(OK)); chk("pr_c1_i_resp", 32'(i2.resp), 32'(NR));
    nxt();
    dq(1, RD, WW, 32'h1004, 0); ds(1, OK, 32'hA02);
    smp(); chk("rr_c2_i_ack", 32'(i1.req_ack), 32'(1)); chk("rr_c2_d_resp", 32'(d1.resp), 32'(OK));
    chk("pr_c2_d_ack", 32'(d2.req_ack), 32'(1)); chk("pr_c2_i_ack", 32'(i2.req_ack), 32'(0));
    nxt();
    iq(1, 32'h208); ds(1, OK, 32'hA03);
    smp(); chk("rr_c3_d_ack", 32'(d1.req_ack), 32'(1)); chk("rr_c3_i_resp", 32'(i1.resp), 32'(OK));
    chk("pr_c3_d_ack", 32'(d2.req_ack), 32'(1)); chk("pr_c3_i_ack", 32'(i2.req_ack), 32'(0));
    nxt();
    iq(0, 0); dq(0, RD, WW, 0, 0); ds(0, OK, 32'hA04);
    smp(); chk("rr_c4_d_resp", 32'(d1.resp), 32'(OK)); chk("rr_c4_d_rdata", d1.rdata, 32'hA04);
    chk("rr_c4_i_resp", 32'(i1.resp), 32'(NR));
    nxt();

    // Single imem read.
    iq(1, 32'h100); ds(1, NR, 0);
    smp(); chk("t1_i_ack", 32'(i1.req_ack), 32'(1)); chk("t1_addr", m1.addr, 32'h100);
    nxt();
    iq(0, 0); ds(0, OK, 32'hDEAD_BEEF);
    smp(); chk("t1_i_resp", 32'(i1.resp), 32'(OK)); chk("t1_i_rdata", i1.rdata, 32'hDEAD_BEEF);
    chk("t1_d_resp", 32'(d1.resp), 32'(NR));
    nxt();

    // Outstanding limit, then simultaneous pop and push while full.
    iq(1, 32'h300); ds(1, NR, 0);
    smp(); nxt();
    iq(0, 0); dq(1, RD, WW, 32'h1008, 0);
    smp(); nxt();
    dq(0, RD, WW, 0, 0); iq(1, 32'h304);
    smp(); chk("full_mem_req", 32'(m1.req), 32'(0)); chk("full_i_ack", 32'(i1.req_ack), 32'(0));
    nxt();
    ds(1, OK, 32'h1111_1111);
    smp(); chk("popush_i_ack", 32'(i1.req_ack), 32'(1)); chk("popush_i_resp", 32'(i1.resp), 32'(OK));
    nxt();
    iq(0, 0); ds(0, OK, 32'h2222_2222);
    smp(); chk("full_d_resp", 32'(d1.resp), 32'(OK)); chk("full_d_rdata", d1.rdata, 32'h2222_2222);
    nxt();
    ds(0, OK, 32'h3333_3333);
    smp(); chk("full_i_resp2", 32'(i1.resp), 32'(OK));
    nxt();

    // dmem byte write with error response, then a stalled and accepted imem read.
    dq(1, WR, SCR1_MEM_WIDTH_BYTE, 32'h2000, 32'hA5); ds(1, NR, 0);
    smp(); chk("wr_d_ack", 32'(d1.req_ack), 32'(1)); chk("wr_cmd", 32'(m1.cmd), 32'(WR));
    chk("wr_width", 32'(m1.width), 32'(SCR1_MEM_WIDTH_BYTE)); chk("wr_wdata", m1.wdata, 32'hA5);
    nxt();
    dq(0, RD, WW, 0, 0); ds(0, ER, 0);
    smp(); chk("er_d_resp", 32'(d1.resp), 32'(ER)); chk("er_i_resp", 32'(i1.resp), 32'(NR));
    nxt();
    iq(1, 32'h400); ds(0, NR, 0);
    smp(); chk("stall_mem_req", 32'(m1.req), 32'(1)); chk("stall_i_ack", 32'(i1.req_ack), 32'(0));
    nxt();
    ds(1, NR, 0);
    smp(); chk("after_er_i_ack", 32'(i1.req_ack), 32'(1));
    nxt();
    iq(0, 0); ds(0, OK, 32'h4444_4444);
    smp(); chk("after_er_i_resp", 32'(i1.resp), 32'(OK));
    nxt();

    // Reset with two outstanding, imem granted last.
    dq(1, RD, WW, 32'h3000, 0); ds(1, NR, 0);
    smp(); nxt();
    dq(0, RD, WW, 0, 0); iq(1, 32'h500);
    smp(); nxt();
    iq(0, 0); ds(0, NR, 0); rst = 1'b1;
    smp(); chk("mid_rst_i_ack", 32'(i1.req_ack), 32'(0)); chk("mid_rst_mem_req", 32'(m1.req), 32'(0));
    chk("mid_rst_pr_mem_req", 32'(m2.req), 32'(0));
    nxt();
    rst = 1'b0; iq(1, 32'h600); dq(1, RD, WW, 32'h3004, 0); ds(1, NR, 0);
    smp(); chk("post_rst_i_ack", 32'(i1.req_ack), 32'(1)); chk("post_rst_d_ack", 32'(d1.req_ack), 32'(0));
    nxt();
    iq(0, 0);
    smp(); chk("post_rst_d_ack2", 32'(d1.req_ack), 32'(1));
    nxt();
    dq(0, RD, WW, 0, 0); ds(0, OK, 32'h5555_5555);
    smp(); chk("post_rst_i_resp", 32'(i1.resp), 32'(OK));
    nxt();
    ds(0, OK, 32'h6666_6666);
    smp(); chk("post_rst_d_resp", 32'(d1.resp), 32'(OK));
    nxt();
    ds(0, NR, 0);
    smp(); nxt();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
